i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- Fabric-side I2C target (responder) with 7-bit addressing and an 8-bit register pointer.
- Sits on the muxed fabric I2C bus (MUX_I2C_SDA/SCL) and answers the HPS I2C0 controller, giving it byte access to a fabric register space.
- Pad side uses split open-drain signals (input plus active-high pull-low enable), compatible with the existing bidirectional pad buffer.
- Register side is a simple synchronous write-strobe / combinational-read port.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit I2C address this target responds to.
- FILT_LEN, 4, consecutive stable ck cycles required before a filtered SCL/SDA level changes (range 1..15).

Ports:
- ck  in  1  system clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
- reg_addr  out  8  current register pointer.
- reg_wdata  out  8  write data; valid while reg_we=1.
- reg_we  out  1  one-cycle write strobe.
- reg_rdata  in  8  read data for reg_addr; sampled combinationally at load time.
- busy  out  1  high from an addressed START until STOP or NACK.

Behaviour:
- Reset (async assert, sync deassert in ck domain):
  - sda_oe=0, reg_we=0, reg_addr=8'h00, reg_wdata=8'h00, busy=0, state=IDLE.
- Input conditioning:
  - 2-FF synchroniser on each input.
  - Filter: scl_f/sda_f take a new level only after the synchronised value differs from the current filtered value for FILT_LEN consecutive cycles. Pulses shorter than that are ignored.
  - Input-to-filtered latency = 2 + FILT_LEN cycles.
- Events, each a single-cycle strobe derived from the filtered signals:
  - rise = scl_f 0->1; fall = scl_f 1->0.
  - START = sda_f 1->0 while scl_f=1.
  - STOP = sda_f 0->1 while scl_f=1.
- Bus timing rules:
  - Data is sampled on rise, MSB first.
  - sda_oe changes only on fall, or on START/STOP/reset.
  - No clock stretching.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- Global transitions:
  - START in any state -> ADDR; clear bit counter; sda_oe=0. This is a repeated START; reg_addr is kept.
  - STOP in any state -> IDLE; sda_oe=0; busy=0.
- ADDR: shift 8 bits. On the fall after bit 8:
  - addr[7:1]==TARGET_ADDR: sda_oe=1, busy=1, enter ADDR_ACK, latch R/W.
  - Otherwise: IDLE, sda_oe stays 0.
- ADDR_ACK, on the next fall:
  - Write (R/W=0): sda_oe=0 -> PTR.
  - Read (R/W=1): load shift register from reg_rdata, drive sda_oe=~bit7 -> RDATA.
- PTR: after 8 bits, reg_addr = received byte; ACK as above -> PTR_ACK -> WDATA.
- WDATA: after 8 bits, at the fall:
  - reg_wdata = byte, reg_we=1 for exactly one cycle, sda_oe=1 (ACK) -> WDATA_ACK.
  - reg_addr increments (mod 256, 8'hFF -> 8'h00) one cycle after reg_we.
  - WDATA_ACK: on the next fall -> WDATA.
- RDATA:
  - On each fall, sda_oe = ~next_bit.
  - After bit 8's fall, release (sda_oe=0) -> RDATA_ACK.
  - On rise in RDATA_ACK, sample the master's response and increment reg_addr (wraps).
  - ACK (sda_f=0): on the next fall, load reg_rdata at the new reg_addr, drive bit7 -> RDATA.
  - NACK: -> IDLE, sda_oe=0, busy=0.
- Other rules:
  - A START/STOP in mid-byte aborts the byte; no reg_we is issued.
  - Reset mid-transfer releases SDA immediately (asynchronously).
  - A START and a fall can never coincide (different conditions on scl_f); if a STOP and a byte-complete fall coincide, the STOP wins.

Test Plan:
- Write: START, 0xA0, 0x10, 0x5A, 0xC3, STOP ->
  - ACK on all four bytes.
  - reg_we pulses twice: (0x10, 0x5A), then (0x11, 0xC3).
  - Final reg_addr=0x12; busy low after STOP.
- Random read: START, 0xA0, 0x20, repeated START, 0xA1; read with master ACK then NACK; reg_rdata model = addr^0xFF ->
  - SDA returns 0xDF then 0xDE.
  - sda_oe=0 after NACK; reg_addr=0x22.
- Address mismatch: START, 0xA2, 0x10, STOP ->
  - sda_oe never asserts, reg_we never asserts, busy stays 0.
- Wrap: pointer 0xFF, write 0x11, 0x22 -> writes land at 0xFF then 0x00.
- Glitch filter with FILT_LEN=4: 2-cycle low pulse on SCL mid-byte -> no bit shifted; the transfer completes normally.
- Reset during RDATA while driving a 0 (sda_oe=1) -> sda_oe=0 within the same cycle, state IDLE.
  - Next transaction to 0x50 after rst_n deassert ACKs normally.

Source files
------------

// File: rtl/i2c_target_regs_if.sv
// Pad-side open-drain I2C signals plus the register-file port of i2c_target_regs.
interface i2c_target_regs_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, busy
    );

    modport master (
        output scl_i, sda_i, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, busy
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with 7-bit address and 8-bit auto-incrementing register pointer,
// giving the HPS I2C controller byte access to a fabric register space.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic             ck,
    input  logic             rst_n,
    i2c_target_regs_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    // Index 0 carries SCL, index 1 carries SDA.
    logic [1:0] sync1, sync2, filt, filt_d;
    logic [3:0] fcnt [2];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            filt_d  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {bus.sda_i, bus.scl_i};
            sync2  <= sync1;
            filt_d <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (fcnt[i] == 4'(FILT_LEN - 1)) begin
                        filt[i] <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 4'd1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_fd, sda_fd;
    logic rise, fall, start_ev, stop_ev;

    assign scl_f    = filt[0];
    assign sda_f    = filt[1];
    assign scl_fd   = filt_d[0];
    assign sda_fd   = filt_d[1];
    assign rise     = scl_f & ~scl_fd;
    assign fall     = ~scl_f & scl_fd;
    assign start_ev = scl_f & scl_fd & sda_fd & ~sda_f;
    assign stop_ev  = scl_f & scl_fd & ~sda_fd & sda_f;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n;
    logic       rw, rw_n;
    logic       oe, oe_n;
    logic [7:0] addr, addr_n;
    logic [7:0] wdata, wdata_n;
    logic       we, we_n;
    logic       busy_q, busy_n;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            rw     <= 1'b0;
            oe     <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            we     <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            shreg  <= shreg_n;
            rw     <= rw_n;
            oe     <= oe_n;
            addr   <= addr_n;
            wdata  <= wdata_n;
            we     <= we_n;
            busy_q <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        rw_n    = rw;
        oe_n    = oe;
        addr_n  = addr;
        wdata_n = wdata;
        we_n    = 1'b0;
        busy_n  = busy_q;

        // Post-write pointer bump lands the cycle after the strobe, whatever else happens.
        if (we)
            addr_n = addr + 8'd1;

        if (stop_ev) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start_ev) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (rise && cnt != 4'd8) begin
                        shreg_n = {shreg[6:0], sda_f};
                        cnt_n   = cnt + 4'd1;
                    end else if (fall && cnt == 4'd8) begin
                        cnt_n = '0;
                        case (state)
                            ADDR: begin
                                if (shreg[7:1] == TARGET_ADDR) begin
                                    oe_n    = 1'b1;
                                    busy_n  = 1'b1;
                                    rw_n    = shreg[0];
                                    state_n = ADDR_ACK;
                                end else begin
                                    busy_n  = 1'b0;
                                    state_n = IDLE;
                                end
                            end
                            PTR: begin
                                addr_n  = shreg;
                                oe_n    = 1'b1;
                                state_n = PTR_ACK;
                            end
                            default: begin
                                wdata_n = shreg;
                                we_n    = 1'b1;
                                oe_n    = 1'b1;
                                state_n = WDATA_ACK;
                            end
                        endcase
                    end
                end
                ADDR_ACK: begin
                    if (fall) begin
                        cnt_n = '0;
                        if (rw) begin
                            shreg_n = bus.reg_rdata;
                            oe_n    = ~bus.reg_rdata[7];
                            state_n = RDATA;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = PTR;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (fall) begin
                        cnt_n   = '0;
                        oe_n    = 1'b0;
                        state_n = WDATA;
                    end
                end
                RDATA: begin
                    if (rise && cnt != 4'd8) begin
                        cnt_n = cnt + 4'd1;
                    end else if (fall) begin
                        if (cnt == 4'd8) begin
                            cnt_n   = '0;
                            oe_n    = 1'b0;
                            state_n = RDATA_ACK;
                        end else begin
                            shreg_n = {shreg[6:0], 1'b0};
                            oe_n    = ~shreg[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    // cnt==1 marks "master ACKed, reload on the coming fall".
                    if (rise) begin
                        addr_n = addr + 8'd1;
                        if (sda_f) begin
                            oe_n    = 1'b0;
                            busy_n  = 1'b0;
                            state_n = IDLE;
                        end else begin
                            cnt_n = 4'd1;
                        end
                    end else if (fall && cnt == 4'd1) begin
                        cnt_n   = '0;
                        shreg_n = bus.reg_rdata;
                        oe_n    = ~bus.reg_rdata[7];
                        state_n = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe    = oe;
    assign bus.reg_addr  = addr;
    assign bus.reg_wdata = wdata;
    assign bus.reg_we    = we;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs; table vectors, hand sequences
// and random transactions checked against a register-array/pointer model.
module tb_i2c_target_regs;
    localparam int Q = 12;

    logic ck = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic mem_clear = 1'b1;

    always #20 ck = ~ck;

    i2c_target_regs_if bus ();

    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    logic [7:0] exp_ptr;

    assign bus.scl_i     = m_scl;
    assign bus.sda_i     = m_sda & ~bus.sda_oe;
    assign bus.reg_rdata = mem[bus.reg_addr];

    i2c_target_regs #(.TARGET_ADDR(7'h50), .FILT_LEN(4)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t wlog [$];
    int  we_run = 0, max_we_run = 0, oe_cycles = 0, busy_cycles = 0;

    always @(negedge ck) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hFF;
        end else if (bus.reg_we) begin
            mem[bus.reg_addr] = bus.reg_wdata;
            wlog.push_back({bus.reg_addr, bus.reg_wdata});
        end
        we_run = bus.reg_we ? we_run + 1 : 0;
        if (we_run > max_we_run) max_we_run = we_run;
        if (bus.sda_oe) oe_cycles++;
        if (bus.busy) busy_cycles++;
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    // glitch_bit selects the bit whose high phase gets a 2-cycle SCL dropout (8 = none).
    task automatic put_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; tick(Q);
            m_scl = 1'b1; tick(Q);
            if (i == glitch_bit) begin
                m_scl = 1'b0; tick(2);
                m_scl = 1'b1; tick(Q);
            end
            m_scl = 1'b0; tick(Q);
        end
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q / 2);
        ack = ~bus.sda_i;
        tick(Q / 2);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic get_byte(input logic master_ack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            m_scl = 1'b1; tick(Q / 2);
            b[i] = bus.sda_i;
            tick(Q / 2);
            m_scl = 1'b0; tick(Q);
        end
        m_sda = ~master_ack; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
        m_sda = 1'b1;
    endtask

    task automatic read_n(input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            get_byte(k != n - 1, b);
            check("rd_byte", b, exp_mem[exp_ptr]);
            exp_ptr = exp_ptr + 8'd1;
        end
    endtask

    typedef struct {
        logic [7:0] dev, ptr;
        int         nd;
        logic [7:0] d0, d1;
        int         glitch;
        logic       exp_ack;
        int         exp_nwr;
        logic [7:0] wa0, wd0, wa1, wd1, exp_final;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic       ack;
        logic [7:0] b, ptr, dev;
        int         nw0, oe0, bz0, n, n_diff;

        vecs[0] = '{dev:8'hA0, ptr:8'h10, nd:2, d0:8'h5A, d1:8'hC3, glitch:8, exp_ack:1'b1,
                    exp_nwr:2, wa0:8'h10, wd0:8'h5A, wa1:8'h11, wd1:8'hC3, exp_final:8'h12};
        vecs[1] = '{dev:8'hA2, ptr:8'h10, nd:0, d0:8'h00, d1:8'h00, glitch:8, exp_ack:1'b0,
                    exp_nwr:0, wa0:8'h00, wd0:8'h00, wa1:8'h00, wd1:8'h00, exp_final:8'h12};
        vecs[2] = '{dev:8'hA0, ptr:8'hFF, nd:2, d0:8'h11, d1:8'h22, glitch:8, exp_ack:1'b1,
                    exp_nwr:2, wa0:8'hFF, wd0:8'h11, wa1:8'h00, wd1:8'h22, exp_final:8'h01};
        vecs[3] = '{dev:8'hA0, ptr:8'h40, nd:1, d0:8'h3C, d1:8'h00, glitch:4, exp_ack:1'b1,
                    exp_nwr:1, wa0:8'h40, wd0:8'h3C, wa1:8'h00, wd1:8'h00, exp_final:8'h41};

        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'hFF;
        exp_ptr = 8'h00;

        tick(4);
        check("rst_sda_oe", bus.sda_oe, 1'b0);
        check("rst_reg_we", bus.reg_we, 1'b0);
        check("rst_reg_addr", bus.reg_addr, 8'h00);
        check("rst_reg_wdata", bus.reg_wdata, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        mem_clear = 1'b0;
        tick(Q);

        for (int v = 0; v < 4; v++) begin
            nw0 = wlog.size();
            oe0 = oe_cycles;
            bz0 = busy_cycles;
            bus_start();
            put_byte(vecs[v].dev, vecs[v].glitch, ack);
            check("dev_ack", ack, vecs[v].exp_ack);
            put_byte(vecs[v].ptr, vecs[v].glitch, ack);
            check("ptr_ack", ack, vecs[v].exp_ack);
            for (int j = 0; j < vecs[v].nd; j++) begin
                put_byte(j == 0 ? vecs[v].d0 : vecs[v].d1, vecs[v].glitch, ack);
                check("data_ack", ack, 1'b1);
            end
            bus_stop();
            tick(Q);
            check("vec_busy_after_stop", bus.busy, 1'b0);
            check("vec_final_addr", bus.reg_addr, vecs[v].exp_final);
            check("vec_nwrites", wlog.size() - nw0, vecs[v].exp_nwr);
            if (vecs[v].exp_nwr >= 1 && wlog.size() > nw0)
                check("vec_write0", wlog[nw0], {vecs[v].wa0, vecs[v].wd0});
            if (vecs[v].exp_nwr >= 2 && wlog.size() > nw0 + 1)
                check("vec_write1", wlog[nw0 + 1], {vecs[v].wa1, vecs[v].wd1});
            check("vec_saw_sda_oe", oe_cycles != oe0, vecs[v].exp_ack);
            check("vec_saw_busy", busy_cycles != bz0, vecs[v].exp_ack);
            if (vecs[v].exp_nwr >= 1) exp_mem[vecs[v].wa0] = vecs[v].wd0;
            if (vecs[v].exp_nwr >= 2) exp_mem[vecs[v].wa1] = vecs[v].wd1;
            exp_ptr = vecs[v].exp_final;
        end

        // Random read with repeated START: pointer 0x20, ACK then NACK.
        bus_start();
        put_byte(8'hA0, 8, ack); check("rr_dev_ack", ack, 1'b1);
        put_byte(8'h20, 8, ack); check("rr_ptr_ack", ack, 1'b1);
        bus_start();
        put_byte(8'hA1, 8, ack); check("rr_rdev_ack", ack, 1'b1);
        get_byte(1'b1, b); check("rr_byte0", b, 8'hDF);
        get_byte(1'b0, b); check("rr_byte1", b, 8'hDE);
        check("rr_sda_oe_after_nack", bus.sda_oe, 1'b0);
        check("rr_busy_after_nack", bus.busy, 1'b0);
        check("rr_reg_addr", bus.reg_addr, 8'h22);
        bus_stop();
        exp_ptr = 8'h22;

        // Reset while the target pulls SDA low for bit 7 of 0x7F.
        bus_start();
        put_byte(8'hA0, 8, ack); check("rst_seq_dev_ack", ack, 1'b1);
        put_byte(8'h80, 8, ack); check("rst_seq_ptr_ack", ack, 1'b1);
        bus_start();
        put_byte(8'hA1, 8, ack); check("rst_seq_rdev_ack", ack, 1'b1);
        check("rst_seq_driving_zero", bus.sda_oe, 1'b1);
        #5 rst_n = 1'b0;
        #1;
        check("rst_seq_async_release", bus.sda_oe, 1'b0);
        check("rst_seq_busy", bus.busy, 1'b0);
        check("rst_seq_reg_addr", bus.reg_addr, 8'h00);
        tick(1);
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(2 * Q);
        nw0 = wlog.size();
        bus_start();
        put_byte(8'hA0, 8, ack); check("post_rst_dev_ack", ack, 1'b1);
        put_byte(8'h30, 8, ack); check("post_rst_ptr_ack", ack, 1'b1);
        put_byte(8'h99, 8, ack); check("post_rst_data_ack", ack, 1'b1);
        bus_stop();
        tick(Q);
        check("post_rst_nwrites", wlog.size() - nw0, 1);
        if (wlog.size() > nw0) check("post_rst_write", wlog[nw0], {8'h30, 8'h99});
        check("post_rst_reg_addr", bus.reg_addr, 8'h31);
        exp_mem[8'h30] = 8'h99;
        exp_ptr = 8'h31;

        // Random transactions against the array/pointer model.
        for (int t = 0; t < 16; t++) begin
            n   = $urandom_range(1, 3);
            nw0 = wlog.size();
            case ($urandom_range(0, 3))
                0: begin
                    ptr = 8'($urandom_range(0, 255));
                    bus_start();
                    put_byte(8'hA0, 8, ack); check("rnd_w_dev_ack", ack, 1'b1);
                    put_byte(ptr, 8, ack); check("rnd_w_ptr_ack", ack, 1'b1);
                    exp_ptr = ptr;
                    for (int k = 0; k < n; k++) begin
                        b = 8'($urandom_range(0, 255));
                        put_byte(b, 8, ack); check("rnd_w_data_ack", ack, 1'b1);
                        exp_mem[exp_ptr] = b;
                        exp_ptr = exp_ptr + 8'd1;
                    end
                    bus_stop();
                    tick(Q);
                    check("rnd_w_nwrites", wlog.size() - nw0, n);
                end
                1: begin
                    ptr = 8'($urandom_range(0, 255));
                    bus_start();
                    put_byte(8'hA0, 8, ack); check("rnd_r_dev_ack", ack, 1'b1);
                    put_byte(ptr, 8, ack); check("rnd_r_ptr_ack", ack, 1'b1);
                    exp_ptr = ptr;
                    bus_start();
                    put_byte(8'hA1, 8, ack); check("rnd_r_rdev_ack", ack, 1'b1);
                    read_n(n);
                    bus_stop();
                    tick(Q);
                end
                2: begin
                    bus_start();
                    put_byte(8'hA1, 8, ack); check("rnd_cur_dev_ack", ack, 1'b1);
                    read_n(n);
                    bus_stop();
                    tick(Q);
                end
                default: begin
                    dev = {7'($urandom_range(0, 127)), 1'($urandom_range(0, 1))};
                    if (dev[7:1] == 7'h50) dev[7:1] = 7'h51;
                    bus_start();
                    put_byte(dev, 8, ack); check("rnd_foreign_nack", ack, 1'b0);
                    bus_stop();
                    tick(Q);
                    check("rnd_foreign_nwrites", wlog.size() - nw0, 0);
                end
            endcase
            check("rnd_reg_addr", bus.reg_addr, exp_ptr);
            check("rnd_busy_idle", bus.busy, 1'b0);
        end

        n_diff = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== exp_mem[i]) n_diff++;
        check("mem_image_diffs", n_diff, 0);
        check("reg_we_pulse_len", max_we_run, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
